// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the UART transmit FIFO.
// Drain FSM encoding and pointer width derivation.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StWait   = 2'd2
    } tx_state_e;

    // One extra wrap bit distinguishes full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 storage array: synchronous write port, asynchronous read port.
// No reset on the array so it maps onto distributed RAM.
module sync_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer ahead of buart: accepts CPU bytes at full rate and drains
// them one at a time into the buart wr/tx_data strobe interface.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic                   wr,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   uart_wr,
    output logic [7:0]             uart_data,
    input  logic                   uart_busy
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned AddrW = PtrW - 1;

    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic            r_overflow;
    logic            r_uart_wr;
    logic [7:0]      r_uart_data;
    tx_state_e       r_state;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic [7:0]      w_rdata;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]) &&
                     (r_wptr[AddrW] != r_rptr[AddrW]);
    // full comes from registered state, so a same-cycle pop never admits a push.
    assign w_push  = wr && !w_full && !flush;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AddrW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr[AddrW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rptr[AddrW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wptr     <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // SETTLE covers the cycle before buart raises busy in response to a strobe.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state     <= StIdle;
            r_rptr      <= '0;
            r_uart_wr   <= 1'b0;
            r_uart_data <= 8'h00;
        end else if (flush) begin
            r_state   <= StIdle;
            r_rptr    <= '0;
            r_uart_wr <= 1'b0;
        end else begin
            r_uart_wr <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_empty && !uart_busy) begin
                        r_uart_data <= w_rdata;
                        r_uart_wr   <= 1'b1;
                        r_rptr      <= r_rptr + PtrW'(1);
                        r_state     <= StSettle;
                    end
                end
                StSettle: begin
                    r_state <= StWait;
                end
                StWait: begin
                    if (!uart_busy) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign level     = r_wptr - r_rptr;
    assign overflow  = r_overflow;
    assign uart_wr   = r_uart_wr;
    assign uart_data = r_uart_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH = 16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_uart_tx_fifo;

    logic       clk;
    logic       resetq;
    logic       wr;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       uart_wr;
    logic [7:0] uart_data;
    logic       uart_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got[$];
    int  viol      = 0;
    bit  auto_busy = 0;
    int  busy_cnt  = 0;

    uart_tx_fifo #(
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .resetq    (resetq),
        .wr        (wr),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .uart_wr   (uart_wr),
        .uart_data (uart_data),
        .uart_busy (uart_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; log strobes and optionally model buart busy (20 cycles).
    task automatic step();
        logic pb;
        pb = uart_busy;
        @(posedge clk);
        #1;
        if (auto_busy) begin
            if (busy_cnt > 0) begin
                uart_busy = 1'b1;
                busy_cnt--;
            end else begin
                uart_busy = 1'b0;
            end
        end
        if (uart_wr === 1'b1) begin
            got.push_back(uart_data);
            if (pb) viol++;
            if (auto_busy) busy_cnt = 20;
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr      = 1'b1;
        wr_data = d;
        step();
        wr      = 1'b0;
    endtask

    initial begin
        logic [7:0] base;
        resetq    = 1'b1;
        wr        = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        uart_busy = 1'b0;

        // Asynchronous reset asserted mid-cycle
        #13 resetq = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_uart_wr", uart_wr, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_uart_data", uart_data, 8'h00);
        step();
        step();
        resetq = 1'b1;
        step();

        // Single byte: push in n, strobe in n+2 only
        push(8'h55);
        chk("sb_empty_n1", empty, 0);
        chk("sb_level_n1", level, 1);
        chk("sb_wr_n1", uart_wr, 0);
        step();
        chk("sb_wr_n2", uart_wr, 1);
        chk("sb_data_n2", uart_data, 8'h55);
        step();
        chk("sb_wr_n3", uart_wr, 0);
        chk("sb_level_n3", level, 0);
        chk("sb_data_hold", uart_data, 8'h55);
        repeat (4) step();

        // Busy handshake
        got.delete();
        viol      = 0;
        busy_cnt  = 0;
        auto_busy = 1'b1;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        repeat (120) step();
        auto_busy = 1'b0;
        uart_busy = 1'b0;
        chk("hs_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("hs_byte0", got[0], 8'h41);
            chk("hs_byte1", got[1], 8'h42);
            chk("hs_byte2", got[2], 8'h43);
        end
        chk("hs_strobe_while_busy", viol, 0);
        chk("hs_empty", empty, 1);
        repeat (4) step();

        // Fill, overflow, drain; three rounds walk the pointers through wrap
        for (int r = 0; r < 3; r++) begin
            base = 8'(r * 32);
            uart_busy = 1'b1;
            for (int i = 0; i < 16; i++) push(base + 8'(i));
            chk("fill_full", full, 1);
            chk("fill_level", level, 16);
            push(base + 8'h10);
            chk("ovf_flag", overflow, 1);
            chk("ovf_level", level, 16);
            chk("ovf_full", full, 1);
            got.delete();
            uart_busy = 1'b0;
            for (int k = 0; k < 100 && got.size() < 16; k++) step();
            chk("drain_count", got.size(), 16);
            for (int i = 0; i < 16; i++) begin
                if (i < got.size()) chk("drain_byte", got[i], base + 8'(i));
            end
            repeat (4) step();
            chk("drain_empty", empty, 1);
            chk("drain_ovf_sticky", overflow, 1);
        end

        // Flush clears sticky overflow
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl0_overflow", overflow, 0);
        chk("fl0_level", level, 0);

        // Full with simultaneous pop: push rejected
        uart_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        chk("sp_full_before", full, 1);
        uart_busy = 1'b0;
        wr        = 1'b1;
        wr_data   = 8'hEE;
        step();
        wr        = 1'b0;
        uart_busy = 1'b1;
        chk("sp_level", level, 15);
        chk("sp_overflow", overflow, 1);
        chk("sp_uart_wr", uart_wr, 1);
        chk("sp_uart_data", uart_data, 8'h60);
        chk("sp_full_after", full, 0);

        // Flush with a same-cycle push, right after a strobe
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        chk("fl_level6", level, 6);
        uart_busy = 1'b0;
        step();
        chk("fl_strobe", uart_wr, 1);
        chk("fl_strobe_data", uart_data, 8'hA0);
        chk("fl_level5", level, 5);
        uart_busy = 1'b1;
        flush     = 1'b1;
        wr        = 1'b1;
        wr_data   = 8'hBB;
        step();
        flush = 1'b0;
        wr    = 1'b0;
        chk("fl_level0", level, 0);
        chk("fl_empty", empty, 1);
        chk("fl_overflow", overflow, 0);
        chk("fl_uart_wr", uart_wr, 0);
        chk("fl_data_kept", uart_data, 8'hA0);
        uart_busy = 1'b0;
        got.delete();
        repeat (20) step();
        chk("fl_no_strobe", got.size(), 0);
        chk("fl_data_final", uart_data, 8'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
